// File: rtl/array_pkg.sv
// Shared constants and types for the array_sum operand loader.
package array_pkg;

  localparam int DEF_N     = 10;
  localparam int DEF_W     = 8;
  localparam int DEF_CHK_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(DEF_N);

  typedef enum logic [1:0] {
    FILL_A,
    FILL_B,
    HOLD
  } state_t;

endpackage

// File: rtl/array_pack_loader_if.sv
// Element stream in, packed operand pair out, for the array_pack_loader.
interface array_pack_loader_if #(
  parameter int N     = array_pkg::DEF_N,
  parameter int W     = array_pkg::DEF_W,
  parameter int CHK_W = array_pkg::DEF_CHK_W
) ();

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   num1;
  logic [N*W-1:0]   num2;
  logic [CHK_W-1:0] chk;
  logic             out_valid;
  logic             out_ack;

  modport master (
    output in_data, in_valid, out_ack,
    input  in_ready, num1, num2, chk, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ack,
    output in_ready, num1, num2, chk, out_valid
  );

endinterface

// File: rtl/pack_shift_reg.sv
// Left-shifting packer: after N enables the first element sits in the top W bits.
module pack_shift_reg
  import array_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           res,
  input  logic           en,
  input  logic [W-1:0]   din,
  output logic [N*W-1:0] q
);

  always_ff @(posedge clk) begin
    if (res) begin
      q <= '0;
    end else if (en) begin
      q <= {q[(N-1)*W-1:0], din};
    end
  end

endmodule

// File: rtl/array_pack_loader.sv
// Fills num1 then num2 from an element stream and holds both, with a checksum,
// until the consumer acknowledges them.
module array_pack_loader
  import array_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int CHK_W = DEF_CHK_W
) (
  input logic                clk,
  input logic                res,
  array_pack_loader_if.slave bus
);

  localparam int IW = idx_width(N);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [CHK_W-1:0] chk_q;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             en_a;
  logic             en_b;
  logic             accept;
  logic             last;

  assign accept = en_a | en_b;
  assign last   = (idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      state <= FILL_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL_A:  if (accept && last) state_nxt = FILL_B;
      FILL_B:  if (accept && last) state_nxt = HOLD;
      HOLD:    if (bus.out_ack) state_nxt = FILL_A;
      default: state_nxt = FILL_A;
    endcase
  end

  // Handshake outputs decode the registered state only, so in_valid never reaches in_ready.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    en_a        = 1'b0;
    en_b        = 1'b0;
    case (state)
      FILL_A: begin
        in_ready_c = 1'b1;
        en_a       = bus.in_valid;
      end
      FILL_B: begin
        in_ready_c = 1'b1;
        en_b       = bus.in_valid;
      end
      HOLD:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      idx <= '0;
    end else if (accept) begin
      idx <= last ? '0 : idx + IW'(1);
    end
  end

  // The first element of a new pair restarts the sum rather than adding to the old one.
  always_ff @(posedge clk) begin
    if (res) begin
      chk_q <= '0;
    end else if (accept) begin
      if (state == FILL_A && idx == '0) begin
        chk_q <= CHK_W'(bus.in_data);
      end else begin
        chk_q <= chk_q + CHK_W'(bus.in_data);
      end
    end
  end

  pack_shift_reg #(.N(N), .W(W)) u_pack_a (
    .clk (clk),
    .res (res),
    .en  (en_a),
    .din (bus.in_data),
    .q   (bus.num1)
  );

  pack_shift_reg #(.N(N), .W(W)) u_pack_b (
    .clk (clk),
    .res (res),
    .en  (en_b),
    .din (bus.in_data),
    .q   (bus.num2)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.chk       = chk_q;

endmodule
